id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Execute-issue stage of the RISC-V core. It sits directly upstream of the ALU and holds one decoded instruction in a single-entry ID/EX register with a valid/ready handshake. It resolves operand forwarding from the EX/MEM and MEM/WB stages and drives `SrcA`, `SrcB` and `ALUControl` into the ALU. It also passes destination and store-data information downstream.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RIDX`, 5, register index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard the held instruction (branch/jump redirect).
- `d_valid`  in  1  decode presents an instruction.
- `d_ready`  out  1  stage can accept this cycle.
- `d_rs1`, `d_rs2`  in  RIDX  source register indices.
- `d_rd`  in  RIDX  destination index.
- `d_rd1`, `d_rd2`  in  XLEN  register-file read data.
- `d_imm`  in  XLEN  sign-extended immediate.
- `d_alusrc`  in  1  1 selects `d_imm` as SrcB.
- `d_alucontrol`  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 101 slt).
- `d_regwrite`  in  1  instruction writes `rd`.
- `m_regwrite`, `m_rd`, `m_result`  in  1/RIDX/XLEN  EX/MEM producer.
- `w_regwrite`, `w_rd`, `w_result`  in  1/RIDX/XLEN  MEM/WB producer.
- `e_valid`  out  1  held instruction valid for the ALU.
- `e_ready`  in  1  downstream consumes this cycle.
- `SrcA`, `SrcB`  out  XLEN  ALU operands.
- `ALUControl`  out  3  ALU opcode.
- `e_rd`  out  RIDX  destination index.
- `e_regwrite`  out  1  write enable, gated with `e_valid`.
- `e_wdata`  out  XLEN  forwarded rs2 value, used as store data.

## Operation
- Held registers: valid, rs1, rs2, rd, rd1, rd2, imm, alusrc, alucontrol, regwrite.
- `d_ready = !e_valid || e_ready`.
- Accept when `d_valid && d_ready`; all fields load and valid becomes 1.
- `e_valid && e_ready` with no accept in the same cycle clears valid.
- Flush: `flush` forces valid to 0 next cycle and overrides any same-cycle accept; the accepted instruction is dropped.
- Forwarding is combinational from the held indices and the live producer inputs:
  - fwdA = rs1 != 0 && m_regwrite && m_rd == rs1 ? m_result : rs1 != 0 && w_regwrite && w_rd == rs1 ? w_result : rd1.
  - EX/MEM has priority over MEM/WB.
  - Register x0 is never forwarded.
  - fwdB follows the same rule with rs2/rd2.
- `SrcA = fwdA`; `SrcB = alusrc ? imm : fwdB`; `e_wdata = fwdB`.
- `ALUControl` = held alucontrol; `e_regwrite = regwrite && e_valid`.
- Unused ALU codes pass through unchanged. No width conversion: all data paths are XLEN.

## Timing
- Reset (synchronous, active-high):
  - valid = 0; all held fields = 0; `ALUControl` = 3'b000.
  - `SrcA = SrcB = e_wdata = 0` when no producer matches.
  - `e_regwrite` = 0; `d_ready` = 1.
- Reset asserted mid-operation discards the held instruction on that edge.
- Latency: an instruction accepted at edge N is visible at the outputs after N, with `e_valid` = 1.
- Throughput: one instruction per cycle when `e_ready` stays high.
- Backpressure: with `e_valid && !e_ready`, all held fields and `ALUControl` are stable.
  - Operand outputs may still change as producer inputs change.
  - `d_ready` = 0.
- Forwarding path adds two mux levels after the registers; there is no registered forwarding.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding muxes as above.
- `ID_EX_FWD_EN` undefined:
  - `SrcA` = held rd1; fwdB = held rd2.
  - All `m_*` and `w_*` inputs are ignored.
  - Hazard avoidance is the responsibility of the upstream hazard unit or software NOPs.
  - Handshake and timing are unchanged.

## Test plan
- Reset held 2 cycles, then released -> `e_valid` = 0, `d_ready` = 1, `SrcA` = 0, `ALUControl` = 000, `e_regwrite` = 0.
- Accept add with rs1 = 3, rs2 = 4, rd1 = 10, rd2 = 5, alusrc = 0, alucontrol = 000 -> next cycle `e_valid` = 1, `SrcA` = 10, `SrcB` = 5.
- Same instruction with m_regwrite = 1, m_rd = 3, m_result = 99, and w_regwrite = 1, w_rd = 3, w_result = 7 -> `SrcA` = 99 (EX/MEM wins).
- Repeat the previous case with the FWD macro undefined -> `SrcA` = 10.
- rs1 = 0 with m_rd = 0, m_regwrite = 1, m_result = 55, rd1 = 0 -> `SrcA` = 0.
- alusrc = 1, imm = 0xFFFF_FFFC, rs2 forwarded from MEM/WB with w_result = 0x1234 -> `SrcB` = 0xFFFF_FFFC, `e_wdata` = 0x1234.
- `e_ready` = 0 for 3 cycles while `d_valid` = 1 -> `d_ready` = 0 and held fields stable; `e_ready` high again -> next instruction accepted on that edge.
- Assert `flush` in the same cycle as an accept -> next cycle `e_valid` = 0, `e_regwrite` = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX issue register: one decoded instruction held behind a valid/ready handshake, feeding the ALU.
// Optional operand forwarding from EX/MEM and MEM/WB is enabled with `define ID_EX_FWD_EN.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            d_valid,
    output logic            d_ready,
    input  logic [RIDX-1:0] d_rs1,
    input  logic [RIDX-1:0] d_rs2,
    input  logic [RIDX-1:0] d_rd,
    input  logic [XLEN-1:0] d_rd1,
    input  logic [XLEN-1:0] d_rd2,
    input  logic [XLEN-1:0] d_imm,
    input  logic            d_alusrc,
    input  logic [2:0]      d_alucontrol,
    input  logic            d_regwrite,
    input  logic            m_regwrite,
    input  logic [RIDX-1:0] m_rd,
    input  logic [XLEN-1:0] m_result,
    input  logic            w_regwrite,
    input  logic [RIDX-1:0] w_rd,
    input  logic [XLEN-1:0] w_result,
    output logic            e_valid,
    input  logic            e_ready,
    output logic [XLEN-1:0] SrcA,
    output logic [XLEN-1:0] SrcB,
    output logic [2:0]      ALUControl,
    output logic [RIDX-1:0] e_rd,
    output logic            e_regwrite,
    output logic [XLEN-1:0] e_wdata
);

    logic            valid_q,      valid_d;
    logic [RIDX-1:0] rs1_q,        rs1_d;
    logic [RIDX-1:0] rs2_q,        rs2_d;
    logic [RIDX-1:0] rd_q,         rd_d;
    logic [XLEN-1:0] rd1_q,        rd1_d;
    logic [XLEN-1:0] rd2_q,        rd2_d;
    logic [XLEN-1:0] imm_q,        imm_d;
    logic            alusrc_q,     alusrc_d;
    logic [2:0]      alucontrol_q, alucontrol_d;
    logic            regwrite_q,   regwrite_d;

    logic            accept;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    assign d_ready = !valid_q || e_ready;
    assign accept  = d_valid && d_ready;

    always_comb begin
        valid_d      = valid_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        alusrc_d     = alusrc_q;
        alucontrol_d = alucontrol_q;
        regwrite_d   = regwrite_q;
        if (accept) begin
            rs1_d        = d_rs1;
            rs2_d        = d_rs2;
            rd_d         = d_rd;
            rd1_d        = d_rd1;
            rd2_d        = d_rd2;
            imm_d        = d_imm;
            alusrc_d     = d_alusrc;
            alucontrol_d = d_alucontrol;
            regwrite_d   = d_regwrite;
        end
        // Flush wins over a same-cycle accept; the fields may load but are never marked valid.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (e_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            alusrc_q     <= 1'b0;
            alucontrol_q <= 3'b000;
            regwrite_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            alusrc_q     <= alusrc_d;
            alucontrol_q <= alucontrol_d;
            regwrite_q   <= regwrite_d;
        end
    end

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger producer, so it takes priority; x0 is hard-wired zero and never forwarded.
    always_comb begin
        fwd_a = rd1_q;
        if (rs1_q != '0 && m_regwrite && m_rd == rs1_q) begin
            fwd_a = m_result;
        end else if (rs1_q != '0 && w_regwrite && w_rd == rs1_q) begin
            fwd_a = w_result;
        end
    end

    always_comb begin
        fwd_b = rd2_q;
        if (rs2_q != '0 && m_regwrite && m_rd == rs2_q) begin
            fwd_b = m_result;
        end else if (rs2_q != '0 && w_regwrite && w_rd == rs2_q) begin
            fwd_b = w_result;
        end
    end
`else
    assign fwd_a = rd1_q;
    assign fwd_b = rd2_q;

    logic unused_fwd;
    assign unused_fwd = ^{m_regwrite, m_rd, m_result, w_regwrite, w_rd, w_result, rs1_q, rs2_q};
`endif

    assign e_valid    = valid_q;
    assign SrcA       = fwd_a;
    assign SrcB       = alusrc_q ? imm_q : fwd_b;
    assign e_wdata    = fwd_b;
    assign ALUControl = alucontrol_q;
    assign e_rd       = rd_q;
    assign e_regwrite = regwrite_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: per-cycle comparison against an instruction-level model plus directed literal checks.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, flush, d_valid, d_ready;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [31:0] d_rd1, d_rd2, d_imm;
    logic        d_alusrc, d_regwrite;
    logic [2:0]  d_alucontrol;
    logic        m_regwrite, w_regwrite;
    logic [4:0]  m_rd, w_rd;
    logic [31:0] m_result, w_result;
    logic        e_valid, e_ready, e_regwrite;
    logic [31:0] SrcA, SrcB, e_wdata;
    logic [2:0]  ALUControl;
    logic [4:0]  e_rd;

    int tests = 0;
    int fails = 0;
    bit armed = 0;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RIDX(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm),
        .d_alusrc(d_alusrc), .d_alucontrol(d_alucontrol), .d_regwrite(d_regwrite),
        .m_regwrite(m_regwrite), .m_rd(m_rd), .m_result(m_result),
        .w_regwrite(w_regwrite), .w_rd(w_rd), .w_result(w_result),
        .e_valid(e_valid), .e_ready(e_ready),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .e_rd(e_rd), .e_regwrite(e_regwrite), .e_wdata(e_wdata)
    );

    typedef struct {
        bit          valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        bit          alusrc, regwrite;
        logic [2:0]  alu;
    } inst_t;

    inst_t held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand value an instruction sees: newest matching producer, else its own register read.
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (FWD && idx != 0 && m_regwrite && m_rd == idx) return m_result;
        if (FWD && idx != 0 && w_regwrite && w_rd == idx) return w_result;
        return rf;
    endfunction

    // Instruction-level model of the single slot.
    always @(posedge clk) begin
        bit slot_free;
        slot_free = !held.valid || e_ready;
        if (reset) begin
            held  = '{default: 0};
            armed = 1;
        end else if (flush) begin
            held.valid = 0;
        end else if (d_valid && slot_free) begin
            held = '{valid: 1, rs1: d_rs1, rs2: d_rs2, rd: d_rd, rd1: d_rd1, rd2: d_rd2,
                     imm: d_imm, alusrc: d_alusrc, regwrite: d_regwrite, alu: d_alucontrol};
        end else if (e_ready) begin
            held.valid = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("e_valid", {31'b0, e_valid}, {31'b0, held.valid});
            chk("d_ready", {31'b0, d_ready}, {31'b0, !held.valid || e_ready});
            chk("e_regwrite", {31'b0, e_regwrite}, {31'b0, held.valid && held.regwrite});
            if (held.valid) begin
                chk("SrcA", SrcA, operand(held.rs1, held.rd1));
                chk("SrcB", SrcB, held.alusrc ? held.imm : operand(held.rs2, held.rd2));
                chk("e_wdata", e_wdata, operand(held.rs2, held.rd2));
                chk("ALUControl", {29'b0, ALUControl}, {29'b0, held.alu});
                chk("e_rd", {27'b0, e_rd}, {27'b0, held.rd});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic alusrc, input logic [2:0] alu, input logic rw);
        d_valid = 1; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd; d_rd1 = rd1; d_rd2 = rd2;
        d_imm = imm; d_alusrc = alusrc; d_alucontrol = alu; d_regwrite = rw;
    endtask

    task automatic clr_prod;
        m_regwrite = 0; m_rd = 0; m_result = 0;
        w_regwrite = 0; w_rd = 0; w_result = 0;
    endtask

    initial begin
        reset = 1; flush = 0; e_ready = 1;
        d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_rd1 = 0; d_rd2 = 0; d_imm = 0;
        d_alusrc = 0; d_alucontrol = 0; d_regwrite = 0;
        clr_prod();
        tick(); tick();
        reset = 0;
        @(negedge clk);
        chk("rst e_valid", {31'b0, e_valid}, 32'd0);
        chk("rst d_ready", {31'b0, d_ready}, 32'd1);
        chk("rst SrcA", SrcA, 32'd0);
        chk("rst SrcB", SrcB, 32'd0);
        chk("rst e_wdata", e_wdata, 32'd0);
        chk("rst ALUControl", {29'b0, ALUControl}, 32'd0);
        chk("rst e_regwrite", {31'b0, e_regwrite}, 32'd0);

        // Plain add, no producers.
        issue(3, 4, 6, 10, 5, 0, 0, 3'b000, 1);
        tick();
        d_valid = 0; e_ready = 0;
        @(negedge clk);
        chk("add e_valid", {31'b0, e_valid}, 32'd1);
        chk("add SrcA", SrcA, 32'd10);
        chk("add SrcB", SrcB, 32'd5);

        // Both producers target rs1; EX/MEM is newer.
        m_regwrite = 1; m_rd = 3; m_result = 99;
        w_regwrite = 1; w_rd = 3; w_result = 7;
        #1;
        chk("fwd prio SrcA", SrcA, FWD ? 32'd99 : 32'd10);
        chk("fwd prio SrcB", SrcB, 32'd5);
        clr_prod();

        // x0 never forwarded.
        e_ready = 1;
        issue(0, 0, 1, 0, 0, 0, 0, 3'b011, 1);
        tick();
        d_valid = 0; e_ready = 0;
        m_regwrite = 1; m_rd = 0; m_result = 55;
        @(negedge clk);
        chk("x0 SrcA", SrcA, 32'd0);
        clr_prod();

        // Immediate operand with store data forwarded from MEM/WB.
        e_ready = 1;
        issue(2, 4, 8, 1, 5, 32'hFFFF_FFFC, 1, 3'b000, 0);
        tick();
        d_valid = 0; e_ready = 0;
        w_regwrite = 1; w_rd = 4; w_result = 32'h1234;
        @(negedge clk);
        chk("imm SrcB", SrcB, 32'hFFFF_FFFC);
        chk("imm e_wdata", e_wdata, FWD ? 32'h1234 : 32'd5);
        chk("imm e_regwrite", {31'b0, e_regwrite}, 32'd0);
        clr_prod();

        // Backpressure: A held for 3 cycles while B waits.
        e_ready = 1;
        issue(5, 6, 9, 32'hA, 32'hB, 0, 0, 3'b101, 1);
        tick();
        e_ready = 0;
        issue(7, 8, 12, 32'hC, 32'hD, 0, 0, 3'b010, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("bp d_ready", {31'b0, d_ready}, 32'd0);
            chk("bp e_rd", {27'b0, e_rd}, 32'd9);
            chk("bp ALUControl", {29'b0, ALUControl}, 32'd5);
        end
        e_ready = 1;
        #1;
        chk("bp release d_ready", {31'b0, d_ready}, 32'd1);
        tick();
        d_valid = 0;
        @(negedge clk);
        chk("bp next e_rd", {27'b0, e_rd}, 32'd12);
        chk("bp next ALUControl", {29'b0, ALUControl}, 32'd2);

        // Back-to-back stream at full rate, including an unused opcode.
        for (int i = 1; i <= 4; i++) begin
            issue(5'(i), 5'(i + 8), 5'(i + 16), 32'(i * 3), 32'(i * 7), 32'(i), 1'(i % 2), 3'(i + 3), 1);
            w_regwrite = 1; w_rd = 5'(i); w_result = 32'(100 + i);
            tick();
        end
        d_valid = 0;
        clr_prod();
        @(negedge clk);
        chk("stream last e_rd", {27'b0, e_rd}, 32'd20);
        chk("stream last ALUControl", {29'b0, ALUControl}, 32'd7);
        tick();

        // Flush overrides a same-cycle accept.
        issue(1, 2, 3, 4, 5, 6, 0, 3'b001, 1);
        flush = 1;
        tick();
        flush = 0; d_valid = 0;
        @(negedge clk);
        chk("flush e_valid", {31'b0, e_valid}, 32'd0);
        chk("flush e_regwrite", {31'b0, e_regwrite}, 32'd0);

        // Reset mid-operation drops the held instruction.
        issue(3, 3, 3, 33, 33, 0, 0, 3'b000, 1);
        tick();
        d_valid = 0; e_ready = 0;
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("midrst e_valid", {31'b0, e_valid}, 32'd0);
        chk("midrst d_ready", {31'b0, d_ready}, 32'd1);
        chk("midrst SrcA", SrcA, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
